// File: rtl/fetch_align_queue.sv
// Instruction fetch queue: word-granular memory fetch feeding a halfword-aligned
// instruction presenter that handles mixed 16/32-bit encodings and straddling words.
module fetch_align_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fence,
    input  logic        stall,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_rvc
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // F_DROP: a transaction issued before a flush is still outstanding; its data is discarded
    typedef enum logic [1:0] {
        F_IDLE,
        F_BUSY,
        F_DROP
    } fetch_state_t;

    fetch_state_t  state;
    logic [31:0]   queue [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [31:0]   addr;
    logic [31:0]   retarget;
    logic [31:0]   pc;

    logic [31:0]   head_word;
    logic [15:0]   next_lo;
    logic          avail;
    logic [31:0]   instr;
    logic          rvc;
    logic          flush;
    logic [31:0]   target;
    logic [31:0]   target_word;
    logic          consume;
    logic          pop;
    logic          push;

    assign head_next = head + 1'b1;
    assign head_word = queue[head];
    assign next_lo   = queue[head_next][15:0];

    // Alignment: a 32-bit instruction at pc[1]=1 straddles the head and next words
    always_comb begin
        avail = 1'b0;
        instr = '0;
        rvc   = 1'b0;
        if (!pc[1]) begin
            if (count != '0) begin
                avail = 1'b1;
                if (head_word[1:0] == 2'b11) begin
                    instr = head_word;
                end else begin
                    instr = {16'h0000, head_word[15:0]};
                    rvc   = 1'b1;
                end
            end
        end else if (head_word[17:16] != 2'b11) begin
            if (count != '0) begin
                avail = 1'b1;
                instr = {16'h0000, head_word[31:16]};
                rvc   = 1'b1;
            end
        end else if (count >= CW'(2)) begin
            avail = 1'b1;
            instr = {next_lo, head_word[31:16]};
        end
    end

    assign flush       = redirect | fence;
    assign target      = redirect ? redirect_pc : pc;
    assign target_word = {target[31:2], 2'b00};

    assign out_valid = avail & ~flush;
    assign consume   = out_valid & ~stall;
    // Only the upper-halfword start or a full word at pc[1]=0 finishes the head word
    assign pop       = consume & (pc[1] | ~rvc);
    assign push      = (state == F_BUSY) & imem_ready & ~flush;
    assign count_nxt = count + CW'(push) - CW'(pop);

    assign imem_valid = (state != F_IDLE);
    assign imem_addr  = addr;
    assign out_pc     = pc;
    assign out_instr  = instr;
    assign out_rvc    = rvc;

    always_ff @(posedge clk) begin
        if (push) begin
            queue[tail] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= F_IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pc       <= RESET_PC;
            addr     <= {RESET_PC[31:2], 2'b00};
            retarget <= {RESET_PC[31:2], 2'b00};
        end else begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                pc    <= target;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head_next;
                end
                count <= count_nxt;
                if (consume) begin
                    pc <= pc + (rvc ? 32'd2 : 32'd4);
                end
            end

            // A new request is only started if the eventual push is guaranteed a free slot
            case (state)
                F_IDLE: begin
                    if (flush) begin
                        addr  <= target_word;
                        state <= F_BUSY;
                    end else if (count_nxt < CW'(DEPTH)) begin
                        state <= F_BUSY;
                    end
                end
                F_BUSY: begin
                    if (imem_ready) begin
                        if (flush) begin
                            addr  <= target_word;
                            state <= F_BUSY;
                        end else begin
                            addr  <= addr + 32'd4;
                            state <= (count_nxt < CW'(DEPTH)) ? F_BUSY : F_IDLE;
                        end
                    end else if (flush) begin
                        retarget <= target_word;
                        state    <= F_DROP;
                    end
                end
                F_DROP: begin
                    if (imem_ready) begin
                        addr  <= flush ? target_word : retarget;
                        state <= F_BUSY;
                    end else if (flush) begin
                        retarget <= target_word;
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Self-checking bench for fetch_align_queue: behavioural memory with programmable
// latency, scoreboard of expected instructions, alignment vector table, corner sequences.
module tb_fetch_align_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rvc;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w0;
        logic [31:0] w1;
        exp_t        e0;
        exp_t        e1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fence;
    logic        stall;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_rvc;

    logic [31:0] mem [256];
    int          lat = 0;
    int          wait_cnt = 0;
    logic        prev_valid = 1'b0;
    int          push_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb [$];
    exp_t        got_exp;
    vec_t        vecs [7];

    fetch_align_queue #(
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fence      (fence),
        .stall      (stall),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_rvc    (out_rvc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Memory: ready after `lat` wait cycles of a transaction, evaluated after the DUT edge
    always @(posedge clk) begin
        #2;
        if (!prev_valid || imem_ready) wait_cnt = 0;
        else wait_cnt++;
        prev_valid = imem_valid;
        if (imem_valid && wait_cnt >= lat) begin
            imem_ready = 1'b1;
            imem_rdata = mem[imem_addr[9:2]];
        end else begin
            imem_ready = 1'b0;
            imem_rdata = 32'hDEADBEEF;
        end
    end

    always @(negedge clk) begin
        if (rst && imem_valid && imem_ready) push_cnt++;
    end

    // Scoreboard: each consumed instruction is compared against the oldest expectation
    always @(negedge clk) begin
        if (rst && out_valid && !stall && sb.size() > 0) begin
            got_exp = sb.pop_front();
            chk("sb_pc", out_pc, got_exp.pc);
            chk("sb_instr", out_instr, got_exp.instr);
            chk("sb_rvc", {31'h0, out_rvc}, {31'h0, got_exp.rvc});
        end
    end

    task automatic start_redirect(input logic [31:0] target);
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = target;
    endtask

    task automatic end_redirect();
        @(negedge clk);
        chk("redirect_blocks_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    task automatic wait_sb(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_pending(input int budget);
        int n = 0;
        @(posedge clk); #3;
        while (!(imem_valid && !imem_ready) && n < budget) begin
            @(posedge clk); #3;
            n++;
        end
        chk("pending_found", {31'h0, imem_valid & ~imem_ready}, 32'h1);
    endtask

    initial begin
        logic [7:0]  idx;
        logic [7:0]  idx1;
        logic [31:0] held;
        int          n;
        int          base;

        for (int i = 0; i < 256; i++) mem[i] = 32'h00000013;

        vecs[0] = '{32'h00000080, 32'h12345678, 32'h00000013,
                    '{32'h00000080, 32'h00005678, 1'b1}, '{32'h00000082, 32'h00001234, 1'b1}};
        vecs[1] = '{32'h00000090, 32'hABCD1237, 32'h00000013,
                    '{32'h00000090, 32'hABCD1237, 1'b0}, '{32'h00000094, 32'h00000013, 1'b0}};
        vecs[2] = '{32'h000000A2, 32'h5552AAAA, 32'h00004501,
                    '{32'h000000A2, 32'h00005552, 1'b1}, '{32'h000000A4, 32'h00004501, 1'b1}};
        vecs[3] = '{32'h000000B2, 32'h0003FFFF, 32'hCAFE8765,
                    '{32'h000000B2, 32'h87650003, 1'b0}, '{32'h000000B6, 32'h0000CAFE, 1'b1}};
        vecs[4] = '{32'h00000102, 32'h00930000, 32'h00000001,
                    '{32'h00000102, 32'h00010093, 1'b0}, '{32'h00000106, 32'h00000000, 1'b1}};
        vecs[5] = '{32'h00000040, 32'h00014501, 32'h00000013,
                    '{32'h00000040, 32'h00004501, 1'b1}, '{32'h00000042, 32'h00000001, 1'b1}};
        vecs[6] = '{32'hFFFFFFFE, 32'h00030000, 32'h00000013,
                    '{32'hFFFFFFFE, 32'h00130003, 1'b0}, '{32'h00000002, 32'h00000000, 1'b1}};

        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; fence = 1'b0; stall = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_imem_valid", {31'h0, imem_valid}, 32'h0);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_out_instr", out_instr, 32'h0);
        chk("reset_out_rvc", {31'h0, out_rvc}, 32'h0);
        chk("reset_out_pc", out_pc, 32'h0);

        // Straight-line 32-bit stream, one instruction per cycle
        for (int k = 0; k < 8; k++) sb.push_back('{32'(4 * k), 32'h00000013, 1'b0});
        @(posedge clk); #1;
        rst = 1'b1;
        chk("release_idle", {31'h0, imem_valid}, 32'h0);
        @(posedge clk); #1;
        chk("first_req_valid", {31'h0, imem_valid}, 32'h1);
        chk("first_req_addr", imem_addr, 32'h0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 8; k++) begin
            chk("stream_valid", {31'h0, out_valid}, 32'h1);
            @(negedge clk);
        end
        wait_sb("stream_drain", 20);

        // Alignment table, each row entered by redirect
        foreach (vecs[v]) begin
            idx       = vecs[v].pc[9:2];
            idx1      = idx + 8'd1;
            mem[idx]  = vecs[v].w0;
            mem[idx1] = vecs[v].w1;
            start_redirect(vecs[v].pc);
            sb.push_back(vecs[v].e0);
            sb.push_back(vecs[v].e1);
            end_redirect();
            chk("redirect_addr", imem_addr, {vecs[v].pc[31:2], 2'b00});
            chk("redirect_pc", out_pc, vecs[v].pc);
            wait_sb("align_row", 40);
        end

        // Continuous stall: queue fills to DEPTH then fetch stops
        stall = 1'b1;
        start_redirect(32'h00000200);
        end_redirect();
        base = push_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("stall_pushes", push_cnt - base, 4);
        chk("stall_fetch_idle", {31'h0, imem_valid}, 32'h0);
        chk("stall_pc", out_pc, 32'h00000200);
        chk("stall_valid", {31'h0, out_valid}, 32'h1);
        chk("stall_instr", out_instr, 32'h00000013);
        chk("stall_rvc", {31'h0, out_rvc}, 32'h0);
        for (int k = 0; k < 8; k++) sb.push_back('{32'h00000200 + 32'(4 * k), 32'h00000013, 1'b0});
        stall = 1'b0;
        wait_sb("stall_release", 30);

        // Redirect while a slow transaction is outstanding
        mem[192] = 32'h00A00093;
        lat = 3;
        wait_pending(20);
        held        = imem_addr;
        redirect    = 1'b1;
        redirect_pc = 32'h00000300;
        sb.push_back('{32'h00000300, 32'h00A00093, 1'b0});
        @(posedge clk); #3;
        redirect = 1'b0;
        n = 0;
        while (!imem_ready && n < 10) begin
            chk("drop_addr_held", imem_addr, held);
            chk("drop_valid_held", {31'h0, imem_valid}, 32'h1);
            chk("drop_no_stale", {31'h0, out_valid}, 32'h0);
            @(posedge clk); #3;
            n++;
        end
        chk("drop_ready_seen", {31'h0, imem_ready}, 32'h1);
        chk("drop_addr_at_ready", imem_addr, held);
        @(posedge clk); #3;
        chk("drop_new_addr", imem_addr, 32'h00000300);
        chk("drop_new_valid", {31'h0, imem_valid}, 32'h1);
        chk("drop_new_no_stale", {31'h0, out_valid}, 32'h0);
        wait_sb("drop_refetch", 20);
        lat = 0;

        // Fence with later words queued: refetch from current pc sees new memory
        stall = 1'b1;
        start_redirect(32'h00000020);
        end_redirect();
        repeat (10) @(posedge clk);
        #1;
        chk("fence_pre_pc", out_pc, 32'h00000020);
        chk("fence_pre_full", {31'h0, imem_valid}, 32'h0);
        mem[8] = 32'h00B00113;
        mem[9] = 32'h00C00193;
        fence  = 1'b1;
        @(negedge clk);
        chk("fence_blocks_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1;
        fence = 1'b0;
        chk("fence_addr", imem_addr, 32'h00000020);
        chk("fence_req_valid", {31'h0, imem_valid}, 32'h1);
        chk("fence_pc", out_pc, 32'h00000020);
        chk("fence_flushed", {31'h0, out_valid}, 32'h0);
        sb.push_back('{32'h00000020, 32'h00B00113, 1'b0});
        sb.push_back('{32'h00000024, 32'h00C00193, 1'b0});
        stall = 1'b0;
        wait_sb("fence_refetch", 20);

        // Reset during an outstanding transaction
        lat = 3;
        wait_pending(20);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_abandon_valid", {31'h0, imem_valid}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        rst = 1'b1;
        sb.push_back('{32'h00000000, 32'h00000013, 1'b0});
        @(posedge clk); #1;
        chk("rst_first_req", {31'h0, imem_valid}, 32'h1);
        chk("rst_first_addr", imem_addr, 32'h0);
        wait_sb("rst_refetch", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_align_queue.md
FETCH_ALIGN_QUEUE -- requirements
Module: fetch_align_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of 32-bit word slots in the queue; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0, first fetch and issue PC after reset; bits [0] SHALL be 0.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 redirect  input  1  flush queue and restart at redirect_pc (exception, mret, jump).
REQ-006 redirect_pc  input  32  target PC, halfword aligned.
REQ-007 fence  input  1  flush queue and refetch from current out_pc.
REQ-008 stall  input  1  downstream not accepting; hold current instruction.
REQ-009 imem_valid  output  1  memory request active.
REQ-010 imem_addr  output  32  word-aligned request address.
REQ-011 imem_ready  input  1  request complete; imem_rdata valid this cycle.
REQ-012 imem_rdata  input  32  fetched word.
REQ-013 out_valid  output  1  out_instr/out_pc hold a complete instruction.
REQ-014 out_pc  output  32  PC of presented instruction.
REQ-015 out_instr  output  32  instruction; upper 16 bits zero when compressed.
REQ-016 out_rvc  output  1  presented instruction is 16-bit (out_instr[1:0] != 2'b11).

Function
REQ-017 Memory handshake: imem_valid, once high, SHALL stay high with imem_addr stable until the cycle imem_ready=1; one transaction outstanding at most.
REQ-018 New request SHALL start only when occupied slots < DEPTH or a drop is pending; fetch address then advances by 4 after each completed transaction, wrapping 32'hFFFFFFFC -> 0.
REQ-019 Completed non-dropped transaction SHALL push {imem_rdata} at queue tail; push and pop in same cycle SHALL be allowed at full and empty boundaries.
REQ-020 Alignment, head pc[1]=0: instruction from head word; 32-bit if word[1:0]==11, else 16-bit word[15:0].
REQ-021 Alignment, head pc[1]=1: if word[17:16]!=11, 16-bit word[31:16]; else 32-bit {next[15:0],head[31:16]}, valid only when two words queued.
REQ-022 out_valid SHALL be 1 only when a complete instruction is queued and redirect=0 and fence=0.
REQ-023 Consume when out_valid=1 and stall=0: out_pc advances by 2 (rvc) or 4; head word popped whenever advance crosses a word boundary (one pop per cycle maximum).
REQ-024 redirect SHALL in the same cycle suppress consumption, and next cycle: queue empty, out_pc=redirect_pc, fetch address=redirect_pc & ~3.
REQ-025 fence (redirect=0) SHALL behave as redirect to the current out_pc; redirect has priority over fence.
REQ-026 Redirect/fence while a transaction is pending SHALL set a drop flag: the pending transaction completes unchanged, its data is discarded, and the new address is issued the following cycle.
REQ-027 Redirect/fence on the cycle imem_ready=1 SHALL discard that data, with no drop flag set.
REQ-028 stall=1 SHALL hold out_pc, out_instr, out_rvc stable; fetching continues until full.
REQ-029 Full queue: imem_valid=0 after any pending transaction completes; empty queue: out_valid=0.

Reset
REQ-030 rst=0 SHALL set: queue empty, drop flag 0, out_pc=RESET_PC, fetch address=RESET_PC & ~3, imem_valid=0, out_valid=0, out_instr=0, out_rvc=0.
REQ-031 Reset during a pending transaction SHALL abandon it; first request after reset is issued the cycle after rst returns high.

Verification
REQ-032 RESET_PC=0, memory returns 0x00000013 per word, ready immediately, stall=0 -> out_pc 0,4,8,... each cycle, out_rvc=0.
REQ-033 Word0=0x00014501 (two RVC: 0x4501, 0x0001) -> out_pc 0 instr 0x4501 rvc=1, then out_pc 2 instr 0x0001 rvc=1, then out_pc 4.
REQ-034 Redirect to 0x102, word@0x100=0x00930000, word@0x104=0x00000001 -> out_pc 0x102, out_instr 0x00010093 after both words arrive, then out_pc 0x106.
REQ-035 DEPTH=4, stall=1 continuously -> exactly 4 pushes, imem_valid low thereafter, out_pc unchanged; release stall -> fetching resumes.
REQ-036 Redirect while imem_valid=1 and ready delayed 3 cycles -> old address held until ready, data discarded, next imem_addr=redirect target, no stale out_valid.
REQ-037 fence at out_pc=0x20 with queue holding later words -> queue flushed, next imem_addr=0x20, out_pc 0x20 re-presented with new memory contents.
